// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: pixel and channel widths and the frame loader FSM encoding.
// The downstream serialiser imports PixW from here so both ends agree on pixel size.
package ws2812_pkg;

  localparam int unsigned PixW    = 24;
  localparam int unsigned ChanW   = 8;
  localparam int unsigned NumChan = PixW / ChanW;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StPresent = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/ws2812_dimmer.sv
// Combinational per-channel brightness scaler: out = (c * (level + 1)) >> 8.
// level 255 is identity, level 0 forces every channel to zero.
module ws2812_dimmer
  import ws2812_pkg::*;
(
  input  logic [PixW-1:0]  pix_i,
  input  logic [ChanW-1:0] level_i,
  output logic [PixW-1:0]  pix_o
);

  logic [ChanW:0] scale;

  assign scale = {1'b0, level_i} + (ChanW + 1)'(1);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [2*ChanW-1:0] prod;
    // 8x9-bit product always fits in 16 bits; keep the upper byte.
    assign prod = (2 * ChanW)'(pix_i[c*ChanW +: ChanW]) * (2 * ChanW)'(scale);
    assign pix_o[c*ChanW +: ChanW] = ChanW'(prod >> ChanW);
  end

endmodule

// File: rtl/ws2812_frame_loader.sv
// WS2812 frame loader: holds a NUM_LEDS x 24-bit pixel buffer written by a host and, on a
// show request, streams every pixel in index order over a valid/ready handshake.
// Optional feature macro: WS2812_BRIGHTNESS_EN adds a global 8-bit brightness input that
// scales each colour channel as the pixel is loaded.
module ws2812_frame_loader
  import ws2812_pkg::*;
#(
  parameter int unsigned  NUM_LEDS = 2,
  localparam int unsigned ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [ChanW-1:0]  brightness,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PixW-1:0]   wr_data,
  input  logic              show,
  output logic [PixW-1:0]   pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_LEDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic [PixW-1:0]   buf_q [NUM_LEDS];
  logic [PixW-1:0]   buf_d [NUM_LEDS];
  logic              wr_hit;
  logic [PixW-1:0]   load_pix;

  // Out-of-range addresses are dropped; compare at 32 bits so non-power-of-2 sizes work.
  assign wr_hit = wr_en && (32'(wr_addr) < NUM_LEDS);

`ifdef WS2812_BRIGHTNESS_EN
  ws2812_dimmer u_dimmer (
    .pix_i   (buf_q[idx_q]),
    .level_i (brightness),
    .pix_o   (load_pix)
  );
`else
  assign load_pix = buf_q[idx_q];
`endif

  // Buffer next-state: a host write lands at the next edge regardless of FSM state.
  always_comb begin
    buf_d = buf_q;
    if (wr_hit) begin
      buf_d[wr_addr] = wr_data;
    end
  end

  // Pixel buffer storage, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

  // Frame sequencing: next state, pixel index, pending request and presented pixel.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    pix_d     = pix_q;

    // Shows arriving mid-frame collapse into a single queued frame.
    if (show && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (show || pending_q) begin
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        // Reads the registered buffer, so a same-cycle write is seen only next frame.
        pix_d   = load_pix;
        state_d = StPresent;
      end
      StPresent: begin
        if (pix_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      pix_q     <= pix_d;
    end
  end

  // Outputs decode directly from state so reset clears them without a clock edge.
  always_comb begin
    pix_data   = pix_q;
    pix_valid  = (state_q == StPresent);
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_ws2812_frame_loader.sv
// Directed self-checking bench for ws2812_frame_loader (NUM_LEDS=2 main instance plus a
// NUM_LEDS=3 instance for out-of-range writes). Brightness checks build with
// WS2812_BRIGHTNESS_EN defined.
module tb_ws2812_frame_loader;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [0:0]  wr_addr;
  logic [23:0] wr_data;
  logic        show;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;

  logic        wr_en3;
  logic [1:0]  wr_addr3;
  logic [23:0] wr_data3;
  logic        show3;
  logic [23:0] pix_data3;
  logic        pix_valid3;
  logic        pix_ready3;
  logic        busy3;
  logic        frame_done3;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  int checks = 0;
  int errors = 0;

  ws2812_frame_loader #(.NUM_LEDS(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .show       (show),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  ws2812_frame_loader #(.NUM_LEDS(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .wr_en      (wr_en3),
    .wr_addr    (wr_addr3),
    .wr_data    (wr_data3),
    .show       (show3),
    .pix_data   (pix_data3),
    .pix_valid  (pix_valid3),
    .pix_ready  (pix_ready3),
    .busy       (busy3),
    .frame_done (frame_done3)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [0:0]  addr;
    logic [23:0] data;
    logic        show;
    logic        ready;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] q3 [$];
    logic [23:0] q1 [$];
    int          bad;
    int          n_done;
    int          idle_between;

    //                wr    a     data         show  rdy   v     exp_data     busy  done
    vecs[0] = '{1'b1, 1'b0, 24'hFF0000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'h00FF00, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'hFF0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'hFF0000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h00FF00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h00FF00, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h00FF00, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h00FF00, 1'b0, 1'b0};

    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; show = 1'b0; pix_ready = 1'b0;
    wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; show3 = 1'b0; pix_ready3 = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    #1;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #20;
    reset_n = 1'b1;

    // Basic two-pixel frame with pix_ready held high.
    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      show = vecs[i].show; pix_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(pix_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].exp_done));
    end
    wr_en = 1'b0; show = 1'b0; pix_ready = 1'b0;

    // Stall 50 cycles in PRESENT; a write to pixel 0 during LOAD must not alter this frame.
    show = 1'b1;
    step();
    show = 1'b0;
    check("stall_load_busy", 32'(busy), 32'd1);
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = 24'h0000AA;
    step();
    wr_en = 1'b0;
    check("stall_old_value", 32'(pix_data), 32'hFF0000);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (!pix_valid || pix_data !== 24'hFF0000) bad++;
    end
    check("stall_stable_bad_cycles", 32'(bad), 32'd0);
    pix_ready = 1'b1;
    step();
    check("stall_release_xfer", 32'(pix_valid), 32'd0);
    step();
    check("stall_pix1", 32'(pix_data), 32'h00FF00);
    step();
    check("stall_done", 32'(frame_done), 32'd1);
    step();
    check("stall_idle", 32'(busy), 32'd0);

    // Two shows during a frame yield exactly one extra frame with one IDLE cycle between.
    n_done = 0;
    idle_between = 0;
    for (int k = 0; k < 30; k++) begin
      show = (k == 0 || k == 2 || k == 4);
      step();
      if (pix_valid) q1.push_back(pix_data);
      if (frame_done) n_done++;
      if (!busy && n_done == 1) idle_between++;
    end
    show = 1'b0;
    check("multi_frames", 32'(n_done), 32'd2);
    check("multi_idle_gap", 32'(idle_between), 32'd1);
    check("multi_npix", 32'(q1.size()), 32'd4);
    if (q1.size() == 4) begin
      check("multi_pix0", 32'(q1[0]), 32'h0000AA);
      check("multi_pix1", 32'(q1[1]), 32'h00FF00);
      check("multi_pix2", 32'(q1[2]), 32'h0000AA);
      check("multi_pix3", 32'(q1[3]), 32'h00FF00);
    end
    pix_ready = 1'b0;

    // Out-of-range write on a three-pixel instance is ignored.
    wr_en3 = 1'b1;
    wr_addr3 = 2'd0; wr_data3 = 24'hA11111; step();
    wr_addr3 = 2'd1; wr_data3 = 24'hB22222; step();
    wr_addr3 = 2'd2; wr_data3 = 24'hC33333; step();
    wr_addr3 = 2'd3; wr_data3 = 24'h123456; step();
    wr_en3 = 1'b0;
    show3 = 1'b1;
    step();
    show3 = 1'b0;
    pix_ready3 = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pix_valid3) q3.push_back(pix_data3);
      if (frame_done3) n_done++;
    end
    pix_ready3 = 1'b0;
    check("oor_npix", 32'(q3.size()), 32'd3);
    check("oor_done", 32'(n_done), 32'd1);
    if (q3.size() == 3) begin
      check("oor_pix0", 32'(q3[0]), 32'hA11111);
      check("oor_pix1", 32'(q3[1]), 32'hB22222);
      check("oor_pix2", 32'(q3[2]), 32'hC33333);
    end

`ifdef WS2812_BRIGHTNESS_EN
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = 24'hFF8040;
    step();
    wr_en = 1'b0;
    brightness = 8'd127;
    show = 1'b1; step(); show = 1'b0;
    step();
    check("bright_127", 32'(pix_data), 32'h7F4020);
    pix_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    pix_ready = 1'b0;
    brightness = 8'd255;
    show = 1'b1; step(); show = 1'b0;
    step();
    check("bright_255", 32'(pix_data), 32'hFF8040);
    pix_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    pix_ready = 1'b0;
`endif

    // Asynchronous reset while a pixel is presented.
    show = 1'b1; step(); show = 1'b0;
    step();
    check("arst_pre_valid", 32'(pix_valid), 32'd1);
    #20;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(pix_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(pix_data), 32'd0);
    @(posedge clk);
    #20;
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (pix_valid || busy || pix_valid3 || busy3) bad++;
    end
    check("arst_no_restart", 32'(bad), 32'd0);
    // Buffer was cleared by reset, so the next frame streams zeros.
    show = 1'b1; step(); show = 1'b0;
    step();
    check("arst_buf_valid", 32'(pix_valid), 32'd1);
    check("arst_buf_zero", 32'(pix_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_loader.md
WS2812_FRAME_LOADER -- requirements
Module: ws2812_frame_loader

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 2, number of pixels held and streamed per frame (minimum 1).
REQ-002 SHALL have localparam ADDR_W = max(1, clog2(NUM_LEDS)), pixel address width.
REQ-003 Ports: clk  in  1  system clock (10 MHz); one clock domain only.
REQ-004 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: wr_en  in  1  host pixel write strobe.
REQ-006 Ports: wr_addr  in  ADDR_W  pixel index to write.
REQ-007 Ports: wr_data  in  24  pixel colour, bit 23 sent first by the downstream serialiser.
REQ-008 Ports: show  in  1  single-cycle request to stream one frame.
REQ-009 Ports: pix_data  out  24  pixel to WS2812 serialiser.
REQ-010 Ports: pix_valid  out  1  pix_data holds a pixel.
REQ-011 Ports: pix_ready  in  1  serialiser accepts pix_data this cycle.
REQ-012 Ports: busy  out  1  frame in progress.
REQ-013 Ports: frame_done  out  1  one-cycle pulse after the last pixel transfers.

Function
REQ-014 SHALL hold a NUM_LEDS x 24 pixel buffer; a write with wr_en=1 and wr_addr<NUM_LEDS SHALL update the entry at the next clk edge, in any state.
REQ-015 A write with wr_addr>=NUM_LEDS SHALL be ignored without side effects.
REQ-016 FSM states: IDLE, LOAD, PRESENT, DONE.
REQ-017 IDLE: on show=1 (or pending=1), SHALL clear pixel index to 0 and go to LOAD; busy=1 from the next cycle.
REQ-018 LOAD: SHALL sample buffer[index] into pix_data and go to PRESENT with pix_valid=1 (one cycle from entry into LOAD to pix_valid).
REQ-019 PRESENT: pix_data and pix_valid SHALL remain stable until pix_valid&&pix_ready; a transfer occurs on that edge.
REQ-020 On transfer with index<NUM_LEDS-1: SHALL drop pix_valid, increment index and go to LOAD.
REQ-021 On transfer with index==NUM_LEDS-1: SHALL drop pix_valid and go to DONE; index SHALL never wrap past NUM_LEDS-1.
REQ-022 DONE: frame_done=1 for exactly one cycle, then go to IDLE with busy=0.
REQ-023 A show while busy SHALL set a pending flag (multiple shows collapse to one); from DONE, with pending set, the FSM SHALL go to IDLE and start a new frame on the following cycle, clearing pending.
REQ-024 A write in the same cycle as LOAD reads the same index SHALL present the old value; the new value applies to the next frame.
REQ-025 pix_ready while pix_valid=0 SHALL have no effect.

Reset
REQ-026 On reset_n=0 (asynchronous): state=IDLE, index=0, pending=0, pix_valid=0, pix_data=0, busy=0, frame_done=0, all buffer entries=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; after release, no frame starts without a new show.

Configuration
REQ-028 Macro WS2812_BRIGHTNESS_EN: when defined, SHALL add input port brightness (8 bits), sampled in LOAD; each 8-bit channel SHALL be output as (c*(brightness+1))>>8 (16-bit intermediate, truncated), so 255 is identity and 0 gives c>>8=0.
REQ-029 Without WS2812_BRIGHTNESS_EN: brightness port absent; pix_data equals the stored entry unchanged.

Structure
REQ-030 Shared package ws2812_pkg SHALL hold the pixel width (24), the channel width (8) and the FSM state encodings; the WS2812 serialiser SHALL use the same pixel width.
REQ-031 The brightness multiplier SHALL be a separate sub-module ws2812_dimmer (combinational, three channel multiplies) and SHALL be instantiated only under the macro.

Verification
REQ-032 NUM_LEDS=2; write 0xFF0000@0 and 0x00FF00@1; show; pix_ready held 1 -> pix_data sequence 0xFF0000 then 0x00FF00; frame_done pulses once, 1 cycle after the second transfer.
REQ-033 Hold pix_ready=0 for 50 cycles in PRESENT -> pix_data/pix_valid stable throughout; transfer on the first cycle with pix_ready=1.
REQ-034 show pulsed twice during a frame -> exactly one extra frame follows; busy stays 1 apart from one IDLE cycle between frames.
REQ-035 Write 0x123456 to wr_addr=NUM_LEDS -> buffer unchanged; the next frame streams prior values.
REQ-036 Assert reset_n=0 while pix_valid=1 -> pix_valid=0 and busy=0 with no clock edge; after release, pix_valid stays 0.
REQ-037 With WS2812_BRIGHTNESS_EN, brightness=127, pixel 0xFF8040 -> pix_data 0x7F4020; brightness=255 -> 0xFF8040.
